seq_signed_divider: RTL and testbench
=====================================

// Module: seq_signed_divider
// PURPOSE
// - Sequential signed divider; the inverse of the team's Booth multiplier. Computes a / b and a % b for two's-complement operands.
// - Uses the same load-then-run protocol as the multiplier, so the datapath controller drives both blocks identically.
// - Radix-2 restoring division on operand magnitudes: one quotient bit per clock, then a sign fix-up cycle.
// PARAMETERS
// - WIDTH  8  operand, quotient and remainder width in bits (two's complement)
// PORTS
// - clk           in   1      single clock; all state updates on posedge
// - reset         in   1      asynchronous, active-high; clears all state and outputs
// - load          in   1      capture a/b; a computation starts on the first edge with load low
// - a             in   WIDTH  signed dividend
// - b             in   WIDTH  signed divisor
// - quotient      out  WIDTH  signed quotient, truncated toward zero; registered
// - remainder     out  WIDTH  signed remainder, same sign as dividend (or 0); registered
// - busy          out  1      high in INIT and ITER and FIXUP
// - done          out  1      high from result write until the next load or reset
// - div_by_zero   out  1      b == 0 for the current result; valid while done
// - overflow      out  1      a == -2^(WIDTH-1) and b == -1; valid while done
// BEHAVIOUR
// - Reset (async): state=IDLE; all outputs 0; operand registers 0; counter 0.
// - States: IDLE, LOADED, ITER, FIXUP, DONE.
//   - IDLE and DONE: wait. load=1 -> LOADED.
//   - LOADED, load=1: re-capture a,b each edge; stay.
//   - LOADED, load=0: this edge is INIT.
//     - b==0: div_by_zero=1, quotient=all-ones, remainder=a, done=1 -> DONE.
//     - Otherwise: latch |a|, |b| (WIDTH+1 bits so -2^(WIDTH-1) is exact), sign_q=a[msb]^b[msb], sign_r=a[msb], partial remainder P=0, count=0 -> ITER.
//   - ITER, one edge per bit:
//     - P' = {P, dividend msb}; shift the dividend left.
//     - If P' >= |b|: P = P'-|b|, shift quotient bit 1 in. Else P = P', shift 0 in.
//     - count++. After WIDTH steps -> FIXUP.
//   - FIXUP, one edge:
//     - quotient = sign_q ? -Q : Q; remainder = sign_r ? -P : P.
//     - overflow = (a==-2^(WIDTH-1) && b==-1); quotient wraps to 0x80 (WIDTH=8), remainder 0.
//     - done=1 -> DONE.
// - Latency: counting the first load-low edge (INIT) as edge 1, done rises on edge WIDTH+2 (10 for WIDTH=8). Divide-by-zero: done rises on edge 1.
// - Outputs change only at the INIT edge (div0 case), the FIXUP edge, on load, or on reset. Otherwise they hold.
// - load=1 in any state (including mid-ITER/FIXUP):
//   - abort the current computation and capture new operands -> LOADED.
//   - done, div_by_zero, overflow cleared on that edge. quotient/remainder cleared to 0.
//   - load has priority over all state transitions; reset has priority over load.
// - Reset mid-operation: immediate return to reset values; no partial result is ever shown.
// - Operands are sampled only while load=1. Changes on a/b after that are ignored until the next load.
// - Invariant at done (non-div0): a == quotient*b + remainder (mod 2^WIDTH); |remainder| < |b|.
// STRUCTURE
// - Shared package div_pkg:
//   - state enum/localparams: IDLE, LOADED, ITER, FIXUP, DONE.
//   - DIV_WIDTH_DEFAULT = 8.
//   - count width = $clog2(WIDTH+1).
// - Sub-module div_step: combinational single restoring step.
//   - Inputs: P, dividend msb, |b|. Outputs: next P, quotient bit.
//   - Instantiated once in the ITER datapath.
// - Top level holds the FSM, counter, operand/magnitude registers, sign fix-up and output registers.
// TESTING
// - 100 / 7: load one cycle, then low -> edge 10: done=1, quotient=14 (0x0E), remainder=2, flags 0.
// - -100 / 7 (0x9C, 0x07) -> quotient=0xF2 (-14), remainder=0xFE (-2). Also 100 / -7 -> 0xF2, 0x02.
// - 5 / 0 -> on edge 1: done=1, div_by_zero=1, quotient=0xFF, remainder=0x05.
// - -128 / -1 -> done=1, overflow=1, quotient=0x80, remainder=0. And -128 / 1 -> 0x80, 0, overflow=0.
// - Reassert load at ITER step 4 of 50/3 with new operands 9/2 -> done, quotient=4, remainder=1; done never pulses for 50/3.
// - Assert reset at ITER step 5 -> outputs, busy, done immediately 0; no output activity until the next load.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the sequential signed divider
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_ITER   = 3'd2,
    ST_FIXUP  = 3'd3,
    ST_DONE   = 3'd4
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_if.sv
// rtl/seq_signed_divider_if.sv - load/result bundle between controller and divider
interface seq_signed_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic             load;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output load, a, b,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  load, a, b,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on magnitudes
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             msb_i,
  input  logic [WIDTH:0]   dvs_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_o
);
  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] p_next;
  logic           unused_top;

  // Shift in the next dividend bit and subtract the divisor when it fits;
  // the restored value is always below |b|, so the top bit is always zero
  always_comb begin
    p_shift = {p_i, msb_i};
    diff    = p_shift - dvs_i;
    q_o     = (p_shift >= dvs_i);
    p_next  = q_o ? diff : p_shift;
  end

  assign p_o        = p_next[WIDTH-1:0];
  assign unused_top = p_next[WIDTH];
endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - radix-2 restoring signed divider, load-then-run protocol
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_signed_divider_if.slave   bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   dvs_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] count_q;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             done_q, dz_q, ovf_q;
  logic             busy;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   b_ext, abs_b;
  logic [WIDTH-1:0] step_p;
  logic             step_q;

  // Magnitudes: |b| is one bit wider so the most negative divisor stays exact
  assign abs_a = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_ext = {b_q[WIDTH-1], b_q};
  assign abs_b = b_q[WIDTH-1] ? -b_ext : b_ext;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i   (p_q),
    .msb_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .p_o   (step_p),
    .q_o   (step_q)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: load overrides everything, a zero divisor skips the iterations
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = ST_LOADED;
    end else begin
      case (state_q)
        ST_LOADED: state_d = (b_q == '0) ? ST_DONE : ST_ITER;
        ST_ITER:   if (count_q == LAST_CNT) state_d = ST_FIXUP;
        ST_FIXUP:  state_d = ST_DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  // Busy covers the INIT edge plus every cycle still producing a result
  always_comb begin
    busy = 1'b0;
    if ((state_q == ST_ITER) || (state_q == ST_FIXUP)) busy = 1'b1;
    if ((state_q == ST_LOADED) && !bus.load)            busy = 1'b1;
  end

  // Datapath: operand capture, INIT setup, one bit per ITER edge, sign fix-up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      count_q     <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (bus.load) begin
      a_q         <= bus.a;
      b_q         <= bus.b;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_LOADED: begin
          if (b_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= a_q;
            dz_q        <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            dvd_q   <= abs_a;
            dvs_q   <= abs_b;
            q_neg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
            r_neg_q <= a_q[WIDTH-1];
            p_q     <= '0;
            quo_q   <= '0;
            count_q <= '0;
          end
        end
        ST_ITER: begin
          p_q     <= step_p;
          quo_q   <= {quo_q[WIDTH-2:0], step_q};
          dvd_q   <= {dvd_q[WIDTH-2:0], 1'b0};
          count_q <= count_q + CNT_W'(1);
        end
        ST_FIXUP: begin
          quotient_q  <= q_neg_q ? -quo_q : quo_q;
          remainder_q <= r_neg_q ? -p_q : p_q;
          ovf_q       <= (a_q == MIN_VAL) && (b_q == '1);
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed self-checking bench for seq_signed_divider
module tb_seq_signed_divider;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  seq_signed_divider_if #(.WIDTH(8)) bus ();

  seq_signed_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One load cycle, then load low; wait for done and check result and latency
  task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eovf, input int elat);
    int lat;
    @(negedge clk);
    bus.load = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.load = 1'b0;
    bus.a = 8'h5A; bus.b = 8'h00;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
    end
    check_eq({tag, " latency"}, lat, elat);
    check_eq({tag, " quotient"}, bus.quotient, eq);
    check_eq({tag, " remainder"}, bus.remainder, er);
    check_eq({tag, " div_by_zero"}, bus.div_by_zero, edz);
    check_eq({tag, " overflow"}, bus.overflow, eovf);
    check_eq({tag, " busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    int done_seen;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset quotient", bus.quotient, 8'h00);
    check_eq("reset remainder", bus.remainder, 8'h00);
    check_eq("reset done", bus.done, 1'b0);
    check_eq("reset busy", bus.busy, 1'b0);
    check_eq("reset flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    run_div("100/7",    8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 10);
    run_div("-100/7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10);
    run_div("100/-7",   8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10);
    run_div("5/0",      8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1'b0, 1);
    run_div("-1/0",     8'hFF,  8'd0,   8'hFF, 8'hFF, 1'b1, 1'b0, 1);
    run_div("-128/-1",  8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 10);
    run_div("-128/1",   8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 10);
    run_div("-7/2",     8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0, 1'b0, 10);
    run_div("7/7",      8'd7,   8'd7,   8'h01, 8'h00, 1'b0, 1'b0, 10);
    run_div("0/5",      8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 1'b0, 10);
    run_div("127/-128", 8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 10);
    run_div("-128/-128",8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 10);

    // Abort 50/3 at ITER step 4 with new operands 9/2
    @(negedge clk);
    bus.load = 1'b1; bus.a = 8'd50; bus.b = 8'd3;
    @(negedge clk);
    bus.load = 1'b0;
    done_seen = 0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1;
    end
    check_eq("abort busy mid-iter", bus.busy, 1'b1);
    @(negedge clk);
    bus.load = 1'b1; bus.a = 8'd9; bus.b = 8'd2;
    @(posedge clk); #1;
    check_eq("abort clears quotient", bus.quotient, 8'h00);
    if (bus.done) done_seen = 1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1;
    end
    check_eq("abort no done for 50/3", done_seen, 0);
    run_div("9/2 after abort", 8'd9, 8'd2, 8'h04, 8'h01, 1'b0, 1'b0, 10);

    // Reset mid-computation after a completed result was on the outputs
    @(negedge clk);
    bus.load = 1'b1; bus.a = 8'd50; bus.b = 8'd3;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midreset busy", bus.busy, 1'b0);
    check_eq("midreset done", bus.done, 1'b0);
    check_eq("midreset outputs", {bus.quotient, bus.remainder}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || (bus.quotient != 8'h00)) done_seen = 1;
    end
    check_eq("post-reset idle", done_seen, 0);
    run_div("50/3 after reset", 8'd50, 8'd3, 8'h10, 8'h02, 1'b0, 1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
